presettable_updown_counter: RTL and testbench

- Parameterised presettable binary up/down counter, modelled on the CMOS MC14516B device, for the MC14500B-based system.
- Counts on the rising clock edge when the active-low carry-in enables it.
- Supports asynchronous clear and synchronous parallel preset.
- Active-low carry-out flags terminal count so several stages can be cascaded ripple-style.

---
 rtl/presettable_updown_counter.sv | 79 +++++++
 tb/tb_presettable_updown_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/presettable_updown_counter.sv
// presettable_updown_counter
//   Presettable binary up/down counter in the style of the MC14516B.
//   The counter clears asynchronously and loads a preset value synchronously.
//   It counts on the rising clock edge while the active-low carry_in is low.
//   The active-low carry_out flags terminal count, so stages can be cascaded
//   ripple-style: the carry_out of one stage feeds carry_in of the next stage.
//
// Parameters
//   size          counter width in bits (>= 1)
//
// Ports
//   clock         counting clock, rising edge active
//   reset         asynchronous active-high clear
//   preset_enable synchronous parallel-load enable (active high)
//   preset        parallel-load value
//   up_down       count direction: 1 = up, 0 = down
//   carry_in      active-low count enable: 0 = count, 1 = hold
//   result        registered count
//   carry_out     active-low terminal-count flag (combinational)
module presettable_updown_counter #(
  parameter int unsigned size = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            preset_enable,
  input  logic [size-1:0] preset,
  input  logic            up_down,
  input  logic            carry_in,
  output logic [size-1:0] result,
  output logic            carry_out
);

  logic [size-1:0] count;
  logic [size-1:0] count_next;
  logic            at_max;
  logic            at_min;

  assign at_max = (count == '1);
  assign at_min = (count == '0);

  // Priority: preset load, then count when enabled, otherwise hold.
  // Count arithmetic wraps naturally modulo 2^size.
  always_comb begin
    count_next = count;
    if (preset_enable) begin
      count_next = preset;
    end else if (!carry_in) begin
      if (up_down) begin
        count_next = count + 1'b1;
      end else begin
        count_next = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // Terminal count depends only on the current state, direction and enable,
  // not on preset_enable, so a cascaded stage sees the ripple immediately.
  always_comb begin
    carry_out = 1'b1;
    if (!carry_in) begin
      if (up_down && at_max) begin
        carry_out = 1'b0;
      end else if (!up_down && at_min) begin
        carry_out = 1'b0;
      end
    end
  end

  assign result = count;

endmodule

// File: tb/tb_presettable_updown_counter.sv
// Self-checking bench for presettable_updown_counter (size = 4).
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// after the rising edge, or shortly after an asynchronous input change.
module tb_presettable_updown_counter;

  localparam int unsigned W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         preset_enable;
  logic [W-1:0] preset;
  logic         up_down;
  logic         carry_in;
  logic [W-1:0] result;
  logic         carry_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    string        name;
  } exp_t;

  typedef struct {
    logic         pe;
    logic [W-1:0] pv;
    logic         ud;
    logic         ci;
    logic [W-1:0] res;
    logic         co;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];

  presettable_updown_counter #(.size(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .preset_enable (preset_enable),
    .preset        (preset),
    .up_down       (up_down),
    .carry_in      (carry_in),
    .result        (result),
    .carry_out     (carry_out)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] r, input logic c);
    checks++;
    if (result !== r || carry_out !== c) begin
      errors++;
      $display("FAIL %s: got result=%b carry_out=%b, required result=%b carry_out=%b",
               name, result, carry_out, r, c);
    end
  endtask

  // Push the expected post-edge values, clock once, then pop and compare.
  task automatic clock_and_check(input logic [W-1:0] r, input logic c, input string name);
    exp_t e;
    sb.push_back('{res: r, co: c, name: name});
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, required one pending entry", name);
    end else begin
      e = sb.pop_front();
      check(e.name, e.res, e.co);
    end
  endtask

  task automatic step(input logic pe, input logic [W-1:0] pv, input logic ud, input logic ci,
                      input logic [W-1:0] r, input logic c, input string name);
    @(negedge clock);
    preset_enable = pe;
    preset        = pv;
    up_down       = ud;
    carry_in      = ci;
    clock_and_check(r, c, name);
  endtask

  initial begin
    // Expected values derived by hand, starting from result = 1011.
    vecs[0]  = '{pe: 1'b1, pv: 4'b0101, ud: 1'b0, ci: 1'b0, res: 4'b0101, co: 1'b1};
    vecs[1]  = '{pe: 1'b0, pv: 4'b0000, ud: 1'b0, ci: 1'b1, res: 4'b0101, co: 1'b1};
    vecs[2]  = '{pe: 1'b0, pv: 4'b0000, ud: 1'b1, ci: 1'b1, res: 4'b0101, co: 1'b1};
    vecs[3]  = '{pe: 1'b0, pv: 4'b1111, ud: 1'b0, ci: 1'b1, res: 4'b0101, co: 1'b1};
    vecs[4]  = '{pe: 1'b0, pv: 4'b0000, ud: 1'b1, ci: 1'b1, res: 4'b0101, co: 1'b1};
    vecs[5]  = '{pe: 1'b0, pv: 4'b0000, ud: 1'b0, ci: 1'b1, res: 4'b0101, co: 1'b1};
    vecs[6]  = '{pe: 1'b0, pv: 4'b0000, ud: 1'b0, ci: 1'b0, res: 4'b0100, co: 1'b1};
    vecs[7]  = '{pe: 1'b0, pv: 4'b0000, ud: 1'b0, ci: 1'b0, res: 4'b0011, co: 1'b1};
    vecs[8]  = '{pe: 1'b0, pv: 4'b0000, ud: 1'b0, ci: 1'b0, res: 4'b0010, co: 1'b1};
    vecs[9]  = '{pe: 1'b0, pv: 4'b0000, ud: 1'b0, ci: 1'b0, res: 4'b0001, co: 1'b1};
    vecs[10] = '{pe: 1'b0, pv: 4'b0000, ud: 1'b0, ci: 1'b0, res: 4'b0000, co: 1'b0};
    vecs[11] = '{pe: 1'b1, pv: 4'b0000, ud: 1'b1, ci: 1'b0, res: 4'b0000, co: 1'b1};
    vecs[12] = '{pe: 1'b1, pv: 4'b0111, ud: 1'b1, ci: 1'b1, res: 4'b0111, co: 1'b1};

    reset         = 1'b1;
    preset_enable = 1'b0;
    preset        = '0;
    up_down       = 1'b1;
    carry_in      = 1'b1;
    #1;
    check("reset_state", 4'b0000, 1'b1);

    // Reset then count up through a full wrap.
    @(negedge clock);
    reset    = 1'b0;
    carry_in = 1'b0;
    #1;
    check("after_release", 4'b0000, 1'b1);
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] r;
      r = W'((i + 1) % 16);
      clock_and_check(r, (r == 4'b1111) ? 1'b0 : 1'b1, $sformatf("count_up_%0d", i));
    end

    // Down wrap from reset; reset also holds across a rising edge.
    @(negedge clock);
    reset    = 1'b1;
    up_down  = 1'b0;
    carry_in = 1'b0;
    #1;
    check("down_reset_terminal", 4'b0000, 1'b0);
    @(posedge clock);
    #1;
    check("reset_held_on_edge", 4'b0000, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    clock_and_check(4'b1111, 1'b1, "down_wrap_1");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 4'b1110, 1'b1, "down_wrap_2");

    // Preset wins over a disabled count, then counting resumes.
    step(1'b1, 4'b1010, 1'b0, 1'b1, 4'b1010, 1'b1, "preset_priority");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 4'b1011, 1'b1, "count_after_preset");

    // Table: load, hold, count down to terminal, load values.
    for (int unsigned k = 0; k < 13; k++) begin
      step(vecs[k].pe, vecs[k].pv, vecs[k].ud, vecs[k].ci, vecs[k].res, vecs[k].co,
           $sformatf("vec_%0d", k));
    end

    // Asynchronous reset between edges, with result = 0111.
    @(negedge clock);
    preset_enable = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mid", 4'b0000, 1'b1);
    @(negedge clock);
    reset         = 1'b0;
    preset_enable = 1'b1;
    preset        = 4'b1111;
    up_down       = 1'b1;
    carry_in      = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (result !== 4'b1111) begin
      errors++;
      $display("FAIL preset_after_reset: got result=%b, required result=1111", result);
    end
    @(negedge clock);
    preset_enable = 1'b0;
    #1;
    check("terminal_up", 4'b1111, 1'b0);

    // Direction change at terminal count.
    up_down = 1'b0;
    #1;
    check("dir_change_co", 4'b1111, 1'b1);
    clock_and_check(4'b1110, 1'b1, "dir_change_count");

    // Hold at the up terminal: carry_in high suppresses carry_out.
    step(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, "hold_at_max");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, "up_wrap");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
